// File: rtl/lsu_ctrl_pkg.sv
// Shared constants, size encodings and the outstanding-entry record for the load/store controller.
package lsu_ctrl_pkg;

  localparam int XLEN                = 32;
  localparam int DTCM_ADDR_WIDTH     = 16;
  localparam int ITAG_WIDTH          = 4;
  localparam int LSU_OUTS_DEPTH      = 2;
  localparam int LSU_OUTS_INFO_WIDTH = ITAG_WIDTH + 6;

  typedef enum logic [1:0] {
    LSU_SIZE_B  = 2'b00,
    LSU_SIZE_HW = 2'b01,
    LSU_SIZE_W  = 2'b10
  } lsu_size_e;

  typedef struct packed {
    logic [ITAG_WIDTH-1:0] itag;
    logic                  read;
    logic                  usign;
    logic [1:0]            size;
    logic [1:0]            addr;
  } lsu_info_t;

endpackage

// File: rtl/lsu_outs_fifo.sv
// Two-entry outstanding-access FIFO; each entry is filled with SRAM read data one cycle after its push.
module lsu_outs_fifo #(
  parameter int INFO_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              push_read,
  input  logic [INFO_W-1:0] push_info,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              pop,
  output logic              head_valid,
  output logic [INFO_W-1:0] head_info,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        cnt
);

  logic [1:0]        valid_r;
  logic [1:0]        dfill_r;
  logic [INFO_W-1:0] info_r [2];
  logic [DATA_W-1:0] data_r [2];
  logic              wptr_r;
  logic              rptr_r;
  logic [1:0]        cnt_r;
  logic              fill_pend_r;
  logic              fill_idx_r;
  logic              fill_read_r;
  logic              head_fill_s;

  // Entry state, pointers, pending-fill tracking and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 2'b00;
      dfill_r     <= 2'b00;
      wptr_r      <= 1'b0;
      rptr_r      <= 1'b0;
      cnt_r       <= 2'd0;
      fill_pend_r <= 1'b0;
      fill_idx_r  <= 1'b0;
      fill_read_r <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        info_r[i] <= '0;
        data_r[i] <= '0;
      end
    end else begin
      if (push) begin
        valid_r[wptr_r] <= 1'b1;
        dfill_r[wptr_r] <= 1'b0;
        info_r[wptr_r]  <= push_info;
        wptr_r          <= ~wptr_r;
      end
      // Stores keep zero data so the write-back value needs no masking later
      if (fill_pend_r) begin
        dfill_r[fill_idx_r] <= 1'b1;
        data_r[fill_idx_r]  <= fill_read_r ? fill_data : '0;
      end
      if (pop) begin
        valid_r[rptr_r] <= 1'b0;
        rptr_r          <= ~rptr_r;
      end
      fill_pend_r <= push;
      fill_idx_r  <= wptr_r;
      fill_read_r <= push_read;
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Head view; the entry being filled this cycle is presented straight from the SRAM
  always_comb begin
    head_fill_s = dfill_r[rptr_r] | (fill_pend_r & (fill_idx_r == rptr_r));
    head_valid  = valid_r[rptr_r] & head_fill_s;
    head_info   = info_r[rptr_r];
    if (dfill_r[rptr_r]) begin
      head_data = data_r[rptr_r];
    end else if (fill_read_r) begin
      head_data = fill_data;
    end else begin
      head_data = '0;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: issues DTCM accesses for AGU commands, tracks two outstanding accesses
// and returns aligned, extended load results to the AGU response and write-back ports.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         agu_cmd_valid,
  output logic                         agu_cmd_ready,
  input  logic [DTCM_ADDR_WIDTH-1:0]   agu_cmd_addr,
  input  logic                         agu_cmd_read,
  input  logic [XLEN-1:0]              agu_cmd_wdata,
  input  logic [XLEN/8-1:0]            agu_cmd_wmask,
  input  logic [ITAG_WIDTH-1:0]        agu_cmd_itag,
  input  logic                         agu_cmd_usign,
  input  logic [1:0]                   agu_cmd_size,
  output logic                         agu_rsp_valid,
  input  logic                         agu_rsp_ready,
  output logic                         dtcm_cs,
  output logic                         dtcm_we,
  output logic [DTCM_ADDR_WIDTH-3:0]   dtcm_addr,
  output logic [XLEN/8-1:0]            dtcm_wem,
  output logic [XLEN-1:0]              dtcm_din,
  input  logic [XLEN-1:0]              dtcm_dout,
  output logic                         lsu_o_valid,
  input  logic                         lsu_o_ready,
  output logic [XLEN-1:0]              lsu_o_wbck_wdat,
  output logic [ITAG_WIDTH-1:0]        lsu_o_wbck_itag,
  output logic                         lsu_o_wbck_read,
  output logic                         lsu_active
);

  logic            accept_s;
  logic            pop_s;
  logic            head_ok_s;
  logic [1:0]      cnt_s;
  lsu_info_t       push_info_s;
  lsu_info_t       head_info_s;
  logic [XLEN-1:0] head_data_s;
  logic [XLEN-1:0] sh_b_s;
  logic [XLEN-1:0] sh_h_s;

  assign agu_cmd_ready = (cnt_s < 2'(LSU_OUTS_DEPTH));
  assign accept_s      = agu_cmd_valid & agu_cmd_ready;

  assign dtcm_cs   = accept_s;
  assign dtcm_we   = ~agu_cmd_read;
  assign dtcm_addr = agu_cmd_addr[DTCM_ADDR_WIDTH-1:2];
  assign dtcm_wem  = agu_cmd_wmask & {(XLEN/8){~agu_cmd_read}};
  assign dtcm_din  = agu_cmd_wdata;

  assign push_info_s = '{itag:  agu_cmd_itag,
                         read:  agu_cmd_read,
                         usign: agu_cmd_usign,
                         size:  agu_cmd_size,
                         addr:  agu_cmd_addr[1:0]};

  lsu_outs_fifo #(
    .INFO_W (LSU_OUTS_INFO_WIDTH),
    .DATA_W (XLEN)
  ) u_outs_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept_s),
    .push_read  (agu_cmd_read),
    .push_info  (push_info_s),
    .fill_data  (dtcm_dout),
    .pop        (pop_s),
    .head_valid (head_ok_s),
    .head_info  (head_info_s),
    .head_data  (head_data_s),
    .cnt        (cnt_s)
  );

  // Both consumers must be ready together, so each valid is gated by the other side's ready
  assign lsu_o_valid   = head_ok_s & agu_rsp_ready;
  assign agu_rsp_valid = head_ok_s & lsu_o_ready;
  assign pop_s         = head_ok_s & lsu_o_ready & agu_rsp_ready;
  assign lsu_active    = (cnt_s != 2'd0);

  assign lsu_o_wbck_itag = head_info_s.itag;
  assign lsu_o_wbck_read = head_info_s.read;

  // Load data extraction and sign/zero extension of the head entry
  always_comb begin
    sh_b_s = head_data_s >> {head_info_s.addr, 3'b000};
    sh_h_s = head_data_s >> {head_info_s.addr[1], 4'b0000};
    if (!head_info_s.read) begin
      lsu_o_wbck_wdat = '0;
    end else begin
      case (head_info_s.size)
        LSU_SIZE_B:  lsu_o_wbck_wdat = {{(XLEN-8){~head_info_s.usign & sh_b_s[7]}}, sh_b_s[7:0]};
        LSU_SIZE_HW: lsu_o_wbck_wdat = {{(XLEN-16){~head_info_s.usign & sh_h_s[15]}}, sh_h_s[15:0]};
        default:     lsu_o_wbck_wdat = head_data_s;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a behavioural DTCM and directed load/store vectors.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        agu_cmd_valid;
  logic        agu_cmd_ready;
  logic [15:0] agu_cmd_addr;
  logic        agu_cmd_read;
  logic [31:0] agu_cmd_wdata;
  logic [3:0]  agu_cmd_wmask;
  logic [3:0]  agu_cmd_itag;
  logic        agu_cmd_usign;
  logic [1:0]  agu_cmd_size;
  logic        agu_rsp_valid;
  logic        agu_rsp_ready;
  logic        dtcm_cs;
  logic        dtcm_we;
  logic [13:0] dtcm_addr;
  logic [3:0]  dtcm_wem;
  logic [31:0] dtcm_din;
  logic [31:0] dtcm_dout = 32'h0;
  logic        lsu_o_valid;
  logic        lsu_o_ready;
  logic [31:0] lsu_o_wbck_wdat;
  logic [3:0]  lsu_o_wbck_itag;
  logic        lsu_o_wbck_read;
  logic        lsu_active;

  typedef struct {
    logic [3:0]  itag;
    logic        read;
    logic [31:0] wdat;
  } exp_t;

  exp_t        exp_q[$];
  int          comp_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mem [0:63];
  logic        mem_ready = 1'b0;

  lsu_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .agu_cmd_valid   (agu_cmd_valid),
    .agu_cmd_ready   (agu_cmd_ready),
    .agu_cmd_addr    (agu_cmd_addr),
    .agu_cmd_read    (agu_cmd_read),
    .agu_cmd_wdata   (agu_cmd_wdata),
    .agu_cmd_wmask   (agu_cmd_wmask),
    .agu_cmd_itag    (agu_cmd_itag),
    .agu_cmd_usign   (agu_cmd_usign),
    .agu_cmd_size    (agu_cmd_size),
    .agu_rsp_valid   (agu_rsp_valid),
    .agu_rsp_ready   (agu_rsp_ready),
    .dtcm_cs         (dtcm_cs),
    .dtcm_we         (dtcm_we),
    .dtcm_addr       (dtcm_addr),
    .dtcm_wem        (dtcm_wem),
    .dtcm_din        (dtcm_din),
    .dtcm_dout       (dtcm_dout),
    .lsu_o_valid     (lsu_o_valid),
    .lsu_o_ready     (lsu_o_ready),
    .lsu_o_wbck_wdat (lsu_o_wbck_wdat),
    .lsu_o_wbck_itag (lsu_o_wbck_itag),
    .lsu_o_wbck_read (lsu_o_wbck_read),
    .lsu_active      (lsu_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DTCM model: preload, byte-masked writes, registered reads; output scrambles when not reading
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0101_0101 * i;
      mem[0] <= 32'h8081_7F02;
      mem[1] <= 32'h1122_3344;
      mem[4] <= 32'hDEAD_BEEF;
      mem[8] <= 32'h8001_0000;
      mem[9] <= 32'h1234_F00D;
      mem_ready <= 1'b1;
    end else begin
      if (dtcm_cs && dtcm_we) begin
        for (int b = 0; b < 4; b++)
          if (dtcm_wem[b]) mem[dtcm_addr[5:0]][8*b +: 8] <= dtcm_din[8*b +: 8];
      end
      if (dtcm_cs && !dtcm_we) dtcm_dout <= mem[dtcm_addr[5:0]];
      else dtcm_dout <= 32'hBAD0_0000 ^ 32'(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write-back handshake is matched against the oldest expected response
  always @(negedge clk) begin
    if (rst_n && lsu_o_valid && lsu_o_ready) begin
      comp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_completion: got itag %h with no expected response", lsu_o_wbck_itag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_itag", 32'(lsu_o_wbck_itag), 32'(e.itag));
        check("wb_read", 32'(lsu_o_wbck_read), 32'(e.read));
        check("wb_wdat", lsu_o_wbck_wdat, e.wdat);
        check("rsp_valid", 32'(agu_rsp_valid), 32'd1);
      end
    end
  end

  task automatic drive(input logic [15:0] addr, input logic rd, input logic [1:0] size,
                       input logic us, input logic [31:0] wdata, input logic [3:0] wmask,
                       input logic [3:0] tag);
    agu_cmd_valid = 1'b1;
    agu_cmd_addr  = addr;
    agu_cmd_read  = rd;
    agu_cmd_size  = size;
    agu_cmd_usign = us;
    agu_cmd_wdata = wdata;
    agu_cmd_wmask = wmask;
    agu_cmd_itag  = tag;
  endtask

  task automatic issue(input logic [15:0] addr, input logic rd, input logic [1:0] size,
                       input logic us, input logic [31:0] wdata, input logic [3:0] wmask,
                       input logic [3:0] tag, input logic expect_rsp, input logic [31:0] exp_wdat,
                       output int acc_cyc);
    bit   accepted;
    exp_t e;
    accepted = 1'b0;
    acc_cyc  = -1;
    drive(addr, rd, size, us, wdata, wmask, tag);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (agu_cmd_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: itag %h never accepted", tag);
    end else begin
      acc_cyc = cyc;
      check("dtcm_cs", 32'(dtcm_cs), 32'd1);
      check("dtcm_addr", 32'(dtcm_addr), 32'(addr[15:2]));
      if (rd) check("dtcm_wem_load", 32'(dtcm_wem), 32'd0);
      else check("dtcm_wem_store", 32'(dtcm_wem), 32'(wmask));
      if (expect_rsp) begin
        e.itag = tag;
        e.read = rd;
        e.wdat = exp_wdat;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    agu_cmd_valid = 1'b0;
  endtask

  int acc;
  int accs[4];
  int base;

  initial begin
    rst_n = 1'b0;
    agu_rsp_ready = 1'b1;
    lsu_o_ready   = 1'b1;
    drive(16'h0, 1'b1, 2'b10, 1'b0, 32'h0, 4'h0, 4'h0);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(agu_cmd_ready), 32'd1);
    check("rst_o_valid", 32'(lsu_o_valid), 32'd0);
    check("rst_rsp_valid", 32'(agu_rsp_valid), 32'd0);
    check("rst_active", 32'(lsu_active), 32'd0);
    check("rst_dtcm_cs", 32'(dtcm_cs), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word load, one-cycle latency
    issue(16'h0010, 1'b1, 2'b10, 1'b0, 32'h0, 4'h0, 4'h3, 1'b1, 32'hDEAD_BEEF, acc);
    idle();
    @(negedge clk);
    check("word_latency_valid", 32'(lsu_o_valid), 32'd1);
    @(posedge clk);
    #1;

    // Byte and half loads, store, size 11 as word
    issue(16'h0003, 1'b1, 2'b00, 1'b0, 32'h0, 4'h0, 4'h1, 1'b1, 32'hFFFF_FF80, acc);
    issue(16'h0003, 1'b1, 2'b00, 1'b1, 32'h0, 4'h0, 4'h2, 1'b1, 32'h0000_0080, acc);
    issue(16'h0001, 1'b1, 2'b00, 1'b0, 32'h0, 4'h0, 4'h4, 1'b1, 32'h0000_007F, acc);
    issue(16'h0000, 1'b1, 2'b00, 1'b0, 32'h0, 4'h0, 4'h5, 1'b1, 32'h0000_0002, acc);
    issue(16'h0022, 1'b1, 2'b01, 1'b0, 32'h0, 4'h0, 4'h6, 1'b1, 32'hFFFF_8001, acc);
    issue(16'h0024, 1'b1, 2'b01, 1'b0, 32'h0, 4'h0, 4'h7, 1'b1, 32'hFFFF_F00D, acc);
    issue(16'h0027, 1'b1, 2'b01, 1'b1, 32'h0, 4'h0, 4'h8, 1'b1, 32'h0000_1234, acc);
    issue(16'h0005, 1'b0, 2'b00, 1'b0, 32'hAAAA_AAAA, 4'b0010, 4'h9, 1'b1, 32'h0, acc);
    issue(16'h0004, 1'b1, 2'b10, 1'b0, 32'h0, 4'h0, 4'hA, 1'b1, 32'h1122_AA44, acc);
    issue(16'h0010, 1'b1, 2'b11, 1'b0, 32'h0, 4'h0, 4'hB, 1'b1, 32'hDEAD_BEEF, acc);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back loads with no back-pressure
    base = comp_cyc.size();
    issue(16'h0010, 1'b1, 2'b10, 1'b0, 32'h0, 4'h0, 4'h8, 1'b1, 32'hDEAD_BEEF, accs[0]);
    issue(16'h0020, 1'b1, 2'b10, 1'b0, 32'h0, 4'h0, 4'h9, 1'b1, 32'h8001_0000, accs[1]);
    issue(16'h0024, 1'b1, 2'b10, 1'b0, 32'h0, 4'h0, 4'hA, 1'b1, 32'h1234_F00D, accs[2]);
    issue(16'h0004, 1'b1, 2'b10, 1'b0, 32'h0, 4'h0, 4'hB, 1'b1, 32'h1122_AA44, accs[3]);
    idle();
    repeat (4) @(posedge clk);
    #1;
    for (int i = 1; i < 4; i++) check("btb_accept_gap", 32'(accs[i] - accs[0]), 32'(i));
    if (comp_cyc.size() < base + 4) begin
      checks++;
      errors++;
      $display("FAIL btb_completions: got %0d expected 4", comp_cyc.size() - base);
    end else begin
      check("btb_first_latency", 32'(comp_cyc[base] - accs[0]), 32'd1);
      for (int i = 1; i < 4; i++)
        check("btb_complete_gap", 32'(comp_cyc[base+i] - comp_cyc[base]), 32'(i));
    end

    // Stall: two accepted, third held off until the FIFO drains
    lsu_o_ready = 1'b0;
    issue(16'h0000, 1'b1, 2'b10, 1'b0, 32'h0, 4'h0, 4'h1, 1'b1, 32'h8081_7F02, acc);
    issue(16'h0013, 1'b1, 2'b00, 1'b0, 32'h0, 4'h0, 4'h2, 1'b1, 32'hFFFF_FFDE, acc);
    drive(16'h0024, 1'b1, 2'b10, 1'b0, 32'h0, 4'h0, 4'h3);
    repeat (3) begin
      @(negedge clk);
      check("stall_cmd_ready", 32'(agu_cmd_ready), 32'd0);
      check("stall_rsp_valid", 32'(agu_rsp_valid), 32'd0);
      check("stall_active", 32'(lsu_active), 32'd1);
      check("stall_hold_wdat", lsu_o_wbck_wdat, 32'h8081_7F02);
    end
    @(posedge clk);
    #1 lsu_o_ready = 1'b1;
    issue(16'h0024, 1'b1, 2'b10, 1'b0, 32'h0, 4'h0, 4'h3, 1'b1, 32'h1234_F00D, acc);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Reset with two outstanding accesses
    lsu_o_ready = 1'b0;
    issue(16'h0000, 1'b1, 2'b10, 1'b0, 32'h0, 4'h0, 4'hC, 1'b0, 32'h0, acc);
    issue(16'h0010, 1'b1, 2'b10, 1'b0, 32'h0, 4'h0, 4'hD, 1'b0, 32'h0, acc);
    idle();
    @(negedge clk);
    check("full_cmd_ready", 32'(agu_cmd_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_o_valid", 32'(lsu_o_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(agu_cmd_ready), 32'd1);
    check("mid_rst_active", 32'(lsu_active), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lsu_o_ready = 1'b1;
    base = comp_cyc.size();
    repeat (5) @(posedge clk);
    #1;
    check("no_stale_completion", 32'(comp_cyc.size() - base), 32'd0);
    issue(16'h0001, 1'b1, 2'b00, 1'b1, 32'h0, 4'h0, 4'hE, 1'b1, 32'h0000_007F, acc);
    idle();

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
